// File: rtl/poly_freeplay_engine.sv
// rtl/poly_freeplay_engine.sv - polyphonic free-play voice allocator, tone generators and buzzer mixer
// Optional build macro HOLD_RELEASE_EN: an expired voice keeps sounding until its key is released.
module poly_freeplay_engine #(
  parameter int NUM_KEYS    = 7,
  parameter int NUM_VOICES  = 2,
  parameter int PERIOD_BITS = 18,
  parameter int OCT_MAX     = 2,
  parameter int OCT_DEFAULT = 1,
  parameter int LEN_BITS    = 2,
  parameter int DUR_UNIT    = 8,
  parameter int TICK_DIV    = 1250000,
  parameter int MIX_DIV     = 64,
  localparam int OW = (OCT_MAX > 0) ? $clog2(OCT_MAX + 1) : 1,
  localparam int KW = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1,
  localparam int VW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1,
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1,
  localparam int MW = (MIX_DIV > 1) ? $clog2(MIX_DIV) : 1,
  localparam int RW = $clog2(DUR_UNIT + 1) + (1 << LEN_BITS) - 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            en,
  input  logic [NUM_KEYS-1:0]             note_key,
  input  logic                            oct_up,
  input  logic                            oct_down,
  input  logic [LEN_BITS-1:0]             length_sel,
  input  logic [NUM_KEYS*PERIOD_BITS-1:0] note_period,
  output logic [NUM_KEYS-1:0]             led,
  output logic                            buzzer,
  output logic [NUM_VOICES-1:0]           voice_active,
  output logic [OW-1:0]                   octave
);

  logic [NUM_KEYS-1:0]    key_q, key_prev_q, pend_q, pend_d;
  logic [OW-1:0]          oct_q, oct_d;
  logic [NUM_VOICES-1:0]  act_q, act_d, ph_q, ph_d;
  logic [KW-1:0]          vkey_q [NUM_VOICES];
  logic [KW-1:0]          vkey_d [NUM_VOICES];
  logic [PERIOD_BITS-1:0] hp_q [NUM_VOICES];
  logic [PERIOD_BITS-1:0] hp_d [NUM_VOICES];
  logic [PERIOD_BITS-1:0] cnt_q [NUM_VOICES];
  logic [PERIOD_BITS-1:0] cnt_d [NUM_VOICES];
  logic [RW-1:0]          rem_q [NUM_VOICES];
  logic [RW-1:0]          rem_d [NUM_VOICES];
  logic [VW-1:0]          steal_q, steal_d, slot_q, slot_d, sel, nxt, idx, hit_v, free_v, avoice;
  logic [TW-1:0]          tick_q, tick_d;
  logic [MW-1:0]          mix_q, mix_d;
  logic                   buz_q, buz_d;
  logic                   alloc, hit, fre, tick_pulse, mix_wrap;
  logic [KW-1:0]          akey;
`ifdef HOLD_RELEASE_EN
  logic [NUM_VOICES-1:0]  exp_q, exp_d;
`endif

  assign tick_pulse   = (tick_q == TW'(TICK_DIV - 1));
  assign mix_wrap     = (mix_q == MW'(MIX_DIV - 1));
  assign voice_active = act_q;
  assign octave       = oct_q;
  assign buzzer       = buz_q;

  always_comb begin
    oct_d = oct_q;
    if (oct_up && !oct_down && oct_q != OW'(OCT_MAX))
      oct_d = oct_q + 1'b1;
    else if (oct_down && !oct_up && oct_q != '0)
      oct_d = oct_q - 1'b1;
  end

  // Allocation target: voice already holding the key, else lowest free voice, else the steal pointer
  always_comb begin
    alloc  = en && (|pend_q);
    akey   = '0;
    hit    = 1'b0;
    fre    = 1'b0;
    hit_v  = '0;
    free_v = '0;
    for (int k = NUM_KEYS - 1; k >= 0; k--)
      if (pend_q[k]) akey = KW'(k);
    for (int v = NUM_VOICES - 1; v >= 0; v--) begin
      if (act_q[v] && vkey_q[v] == akey) begin
        hit   = 1'b1;
        hit_v = VW'(v);
      end
      if (!act_q[v]) begin
        fre    = 1'b1;
        free_v = VW'(v);
      end
    end
    avoice = hit ? hit_v : (fre ? free_v : steal_q);
  end

  always_comb begin
    steal_d = steal_q;
    if (alloc && !hit && !fre)
      steal_d = (steal_q == VW'(NUM_VOICES - 1)) ? '0 : steal_q + 1'b1;
    pend_d = '0;
    if (en) begin
      pend_d = pend_q | (key_q & ~key_prev_q);
      if (alloc && !(key_q[akey] && !key_prev_q[akey]))
        pend_d[akey] = 1'b0;
    end
    tick_d = (!en || tick_pulse) ? '0 : tick_q + 1'b1;
    mix_d  = (!en || mix_wrap) ? '0 : mix_q + 1'b1;
  end

  // Mixer: an idle slot falls through to the next active voice so a lone voice is never muted
  always_comb begin
    sel = slot_q;
    nxt = slot_q;
    idx = '0;
    if (!act_q[slot_q])
      for (int k = NUM_VOICES - 1; k >= 1; k--) begin
        idx = VW'((int'(slot_q) + k) % NUM_VOICES);
        if (act_q[idx]) sel = idx;
      end
    for (int k = NUM_VOICES; k >= 1; k--) begin
      idx = VW'((int'(sel) + k) % NUM_VOICES);
      if (act_q[idx]) nxt = idx;
    end
    slot_d = !en ? '0 : ((mix_wrap && |act_q) ? nxt : slot_q);
    buz_d  = en && (|act_q) && ph_q[sel];
  end

  always_comb begin
    act_d  = act_q;
    ph_d   = ph_q;
    vkey_d = vkey_q;
    hp_d   = hp_q;
    cnt_d  = cnt_q;
    rem_d  = rem_q;
`ifdef HOLD_RELEASE_EN
    exp_d  = exp_q;
`endif
    for (int v = 0; v < NUM_VOICES; v++) begin
      if (!en) begin
        act_d[v] = 1'b0;
        ph_d[v]  = 1'b0;
        cnt_d[v] = '0;
`ifdef HOLD_RELEASE_EN
        exp_d[v] = 1'b0;
`endif
      end else begin
        if (act_q[v]) begin
          if (hp_q[v] == '0) begin
            cnt_d[v] = '0;
            ph_d[v]  = 1'b0;
          end else if (cnt_q[v] == hp_q[v] - 1'b1) begin
            cnt_d[v] = '0;
            ph_d[v]  = ~ph_q[v];
          end else begin
            cnt_d[v] = cnt_q[v] + 1'b1;
          end
          if (tick_pulse) begin
            if (rem_q[v] != '0) begin
              rem_d[v] = rem_q[v] - 1'b1;
            end else begin
`ifdef HOLD_RELEASE_EN
              if (key_q[vkey_q[v]]) exp_d[v] = 1'b1;
              else begin act_d[v] = 1'b0; ph_d[v] = 1'b0; cnt_d[v] = '0; end
`else
              act_d[v] = 1'b0;
              ph_d[v]  = 1'b0;
              cnt_d[v] = '0;
`endif
            end
          end
`ifdef HOLD_RELEASE_EN
          if (exp_q[v] && !key_q[vkey_q[v]]) begin
            act_d[v] = 1'b0;
            ph_d[v]  = 1'b0;
            cnt_d[v] = '0;
            exp_d[v] = 1'b0;
          end
`endif
        end
        if (alloc && avoice == VW'(v)) begin
          act_d[v]  = 1'b1;
          ph_d[v]   = 1'b0;
          cnt_d[v]  = '0;
          vkey_d[v] = akey;
          hp_d[v]   = note_period[int'(akey)*PERIOD_BITS +: PERIOD_BITS] >> oct_q;
          rem_d[v]  = RW'(DUR_UNIT) << length_sel;
`ifdef HOLD_RELEASE_EN
          exp_d[v]  = 1'b0;
`endif
        end
      end
    end
  end

  always_comb begin
    led = '0;
    for (int v = 0; v < NUM_VOICES; v++)
      if (act_q[v]) led[vkey_q[v]] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_q      <= '0;
      key_prev_q <= '0;
      pend_q     <= '0;
      oct_q      <= OW'(OCT_DEFAULT);
      act_q      <= '0;
      ph_q       <= '0;
      steal_q    <= '0;
      slot_q     <= '0;
      tick_q     <= '0;
      mix_q      <= '0;
      buz_q      <= 1'b0;
`ifdef HOLD_RELEASE_EN
      exp_q      <= '0;
`endif
      for (int v = 0; v < NUM_VOICES; v++) begin
        vkey_q[v] <= '0;
        hp_q[v]   <= '0;
        cnt_q[v]  <= '0;
        rem_q[v]  <= '0;
      end
    end else begin
      key_q      <= note_key;
      key_prev_q <= key_q;
      pend_q     <= pend_d;
      oct_q      <= oct_d;
      act_q      <= act_d;
      ph_q       <= ph_d;
      steal_q    <= steal_d;
      slot_q     <= slot_d;
      tick_q     <= tick_d;
      mix_q      <= mix_d;
      buz_q      <= buz_d;
`ifdef HOLD_RELEASE_EN
      exp_q      <= exp_d;
`endif
      vkey_q     <= vkey_d;
      hp_q       <= hp_d;
      cnt_q      <= cnt_d;
      rem_q      <= rem_d;
    end
  end

endmodule

// File: tb/tb_poly_freeplay_engine.sv
// tb/tb_poly_freeplay_engine.sv - self-checking bench for poly_freeplay_engine
module tb_poly_freeplay_engine;
  localparam int NK = 7, NV = 2, PB = 18, OM = 2, OD = 1, LB = 2, DU = 4, TD = 10, MD = 4;
`ifdef HOLD_RELEASE_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en, oct_up, oct_down;
  logic [NK-1:0] note_key;
  logic [LB-1:0] length_sel;
  logic [NK*PB-1:0] note_period;
  logic [NK-1:0] led;
  logic buzzer;
  logic [NV-1:0] voice_active;
  logic [1:0] octave;

  always #5 clk = ~clk;

  poly_freeplay_engine #(
    .NUM_KEYS(NK), .NUM_VOICES(NV), .PERIOD_BITS(PB), .OCT_MAX(OM), .OCT_DEFAULT(OD),
    .LEN_BITS(LB), .DUR_UNIT(DU), .TICK_DIV(TD), .MIX_DIV(MD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .note_key(note_key), .oct_up(oct_up),
    .oct_down(oct_down), .length_sel(length_sel), .note_period(note_period),
    .led(led), .buzzer(buzzer), .voice_active(voice_active), .octave(octave)
  );

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Reference model: one record per voice, advanced once per clock from the behavioural rules
  typedef struct { bit act; int key; int hp; int cnt; bit ph; int rem; bit expd; } voice_t;
  voice_t mv[NV];
  bit [NK-1:0] m_now, m_prev, m_pend;
  int m_oct, m_steal, m_tick, m_mix, m_slot;
  bit m_buz;
  int base[NK];

  task automatic model_reset();
    for (int v = 0; v < NV; v++) mv[v] = '{0, 0, 0, 0, 0, 0, 0};
    m_now = '0; m_prev = '0; m_pend = '0;
    m_oct = OD; m_steal = 0; m_tick = 0; m_mix = 0; m_slot = 0; m_buz = 0;
  endtask

  task automatic release_voice(input int v);
    mv[v].act = 0; mv[v].ph = 0; mv[v].cnt = 0; mv[v].expd = 0;
  endtask

  task automatic model_step();
    voice_t ov[NV];
    bit [NK-1:0] onow, oprev, opend;
    int ooct, sel, k, t;
    bit any, tick, wrap, found;
    if (!rst_n) begin model_reset(); return; end
    ov = mv; onow = m_now; oprev = m_prev; opend = m_pend; ooct = m_oct;
    if (oct_up && !oct_down && m_oct < OM) m_oct = m_oct + 1;
    else if (oct_down && !oct_up && m_oct > 0) m_oct = m_oct - 1;
    m_prev = onow;
    m_now = note_key;
    if (!en) begin
      for (int v = 0; v < NV; v++) release_voice(v);
      m_pend = '0; m_tick = 0; m_mix = 0; m_slot = 0; m_buz = 0;
      return;
    end
    any = 0;
    for (int v = 0; v < NV; v++) any |= ov[v].act;
    sel = m_slot;
    if (!ov[sel].act)
      for (int j = 1; j < NV; j++) if (ov[(m_slot + j) % NV].act) begin sel = (m_slot + j) % NV; break; end
    m_buz = any ? ov[sel].ph : 1'b0;
    wrap = (m_mix == MD - 1);
    m_mix = wrap ? 0 : m_mix + 1;
    if (wrap && any)
      for (int j = 1; j <= NV; j++) if (ov[(sel + j) % NV].act) begin m_slot = (sel + j) % NV; break; end
    tick = (m_tick == TD - 1);
    m_tick = tick ? 0 : m_tick + 1;
    for (int v = 0; v < NV; v++) if (ov[v].act) begin
      if (ov[v].hp == 0) begin mv[v].cnt = 0; mv[v].ph = 0; end
      else if (ov[v].cnt == ov[v].hp - 1) begin mv[v].cnt = 0; mv[v].ph = !ov[v].ph; end
      else mv[v].cnt = ov[v].cnt + 1;
      if (tick) begin
        if (ov[v].rem > 0) mv[v].rem = ov[v].rem - 1;
        else if (HOLD && onow[ov[v].key]) mv[v].expd = 1;
        else release_voice(v);
      end
      if (HOLD && ov[v].expd && !onow[ov[v].key]) release_voice(v);
    end
    m_pend = opend;
    if (opend != '0) begin
      k = 0;
      while (!opend[k]) k++;
      m_pend[k] = 0;
      found = 0; t = m_steal;
      for (int v = 0; v < NV && !found; v++) if (ov[v].act && ov[v].key == k) begin t = v; found = 1; end
      for (int v = 0; v < NV && !found; v++) if (!ov[v].act) begin t = v; found = 1; end
      if (!found) m_steal = (m_steal + 1) % NV;
      mv[t] = '{1, k, base[k] >> ooct, 0, 0, DU << length_sel, 0};
    end
    m_pend |= onow & ~oprev;
  endtask

  task automatic check_model();
    logic [NV-1:0] ea;
    logic [NK-1:0] el;
    ea = '0; el = '0;
    for (int v = 0; v < NV; v++) if (mv[v].act) begin ea[v] = 1'b1; el[mv[v].key] = 1'b1; end
    chk("model_active", voice_active, ea);
    chk("model_led", led, el);
    chk("model_octave", octave, m_oct);
    chk("model_buzzer", buzzer, m_buz);
  endtask

  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
    check_model();
  endtask

  task automatic cycn(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  typedef struct { logic [NK-1:0] keys; bit up; bit dn; logic [NV-1:0] act; logic [NK-1:0] led; int oct; } vec_t;
  vec_t tv[13];

  task automatic run_vec(input int i);
    note_key = tv[i].keys; oct_up = tv[i].up; oct_down = tv[i].dn;
    cyc();
    chk($sformatf("vec%0d_active", i), voice_active, tv[i].act);
    chk($sformatf("vec%0d_led", i), led, tv[i].led);
    chk($sformatf("vec%0d_octave", i), octave, tv[i].oct);
  endtask

  initial begin
    int n, h, l;
    tv[0]  = '{7'b0000000, 1, 0, 2'b00, 7'b0000000, 2};
    tv[1]  = '{7'b0000000, 1, 0, 2'b00, 7'b0000000, 2};
    tv[2]  = '{7'b0000000, 1, 0, 2'b00, 7'b0000000, 2};
    tv[3]  = '{7'b0000000, 1, 1, 2'b00, 7'b0000000, 2};
    tv[4]  = '{7'b0000000, 0, 1, 2'b00, 7'b0000000, 1};
    tv[5]  = '{7'b0000100, 0, 0, 2'b00, 7'b0000000, 1};
    tv[6]  = '{7'b0000100, 0, 0, 2'b00, 7'b0000000, 1};
    tv[7]  = '{7'b0000100, 0, 0, 2'b01, 7'b0000100, 1};
    tv[8]  = '{7'b0000000, 0, 0, 2'b01, 7'b0000100, 1};
    tv[9]  = '{7'b0101000, 0, 0, 2'b00, 7'b0000000, 1};
    tv[10] = '{7'b0101000, 0, 0, 2'b00, 7'b0000000, 1};
    tv[11] = '{7'b0101000, 0, 0, 2'b01, 7'b0001000, 1};
    tv[12] = '{7'b0101000, 0, 0, 2'b11, 7'b0101000, 1};
    for (int i = 0; i < NK; i++) begin
      base[i] = (i == 6) ? 0 : 60 + 20 * i;
      note_period[i*PB +: PB] = PB'(base[i]);
    end
    en = 1'b1; oct_up = 1'b0; oct_down = 1'b0; note_key = '0; length_sel = '0;
    model_reset();
    cycn(3);
    chk("reset_active", voice_active, 0);
    chk("reset_led", led, 0);
    chk("reset_buzzer", buzzer, 0);
    chk("reset_octave", octave, OD);
    rst_n = 1'b1;

    for (int i = 0; i <= 8; i++) run_vec(i);
    n = 1;
    while (voice_active != 0 && n < 200) begin cyc(); n++; end
    chk("free_window_40_50", (n >= 40 && n <= 50), 1);

    for (int i = 9; i <= 12; i++) run_vec(i);
    note_key = '0;
    n = 0;
    while (voice_active != 0 && n < 200) begin cyc(); n++; end
    chk("idle_after_pair", voice_active, 0);

    length_sel = 2'd3; note_key = 7'b0000100;
    n = 0;
    while (buzzer !== 1'b1 && n < 300) begin cyc(); n++; end
    chk("buzzer_rises", buzzer, 1);
    h = 0;
    while (buzzer === 1'b1 && h < 300) begin cyc(); h++; end
    chk("buzzer_high_len", h, 50);
    l = 0;
    while (buzzer === 1'b0 && l < 300) begin cyc(); l++; end
    chk("buzzer_low_len", l, 50);

    en = 1'b0; note_key = '0;
    cyc();
    en = 1'b1;
    cycn(2);
    note_key = 7'b0000001; cycn(5);
    note_key = 7'b0000011; cycn(5);
    note_key = 7'b0000111; cycn(4);
    chk("steal_active", voice_active, 2'b11);
    chk("steal_led", led, 7'b0000110);
    note_key = 7'b0000101; cycn(2);
    note_key = 7'b0000111; cycn(4);
    chk("retrigger_led", led, 7'b0000110);
    note_key = 7'b0001111; cycn(4);
    chk("steal_ptr_led", led, 7'b0001100);

    en = 1'b0;
    cyc();
    chk("disable_active", voice_active, 0);
    chk("disable_led", led, 0);
    chk("disable_buzzer", buzzer, 0);
    en = 1'b1;
    cycn(5);
    chk("held_keys_no_alloc", voice_active, 0);
    note_key = '0; cycn(2);

    length_sel = '0; note_key = 7'b0010000;
`ifdef HOLD_RELEASE_EN
    cycn(120);
    chk("hold_still_active", voice_active, 2'b01);
    note_key = '0; cycn(3);
    chk("hold_freed_on_release", voice_active, 0);
`else
    cycn(70);
    chk("expire_while_held", voice_active, 0);
`endif
    note_key = '0; cycn(2);

    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 7) == 0) note_key[$urandom_range(0, NK - 1)] ^= 1'b1;
      oct_up = ($urandom_range(0, 29) == 0);
      oct_down = ($urandom_range(0, 29) == 0);
      length_sel = LB'($urandom_range(0, 1));
      en = ($urandom_range(0, 199) != 0);
      cyc();
    end
    oct_up = 1'b0; oct_down = 1'b0; en = 1'b1;

    note_key = '0; cycn(2);
    note_key = 7'b0000010; cycn(3);
    chk("pre_reset_active", voice_active != 0, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_active", voice_active, 0);
    chk("async_reset_led", led, 0);
    chk("async_reset_buzzer", buzzer, 0);
    chk("async_reset_octave", octave, OD);
    model_reset();
    cycn(2);
    rst_n = 1'b1;
    cycn(30);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
